// File: rtl/kernel_bc_stream_pack.sv
// Packs DATA_WIDTH words popped from an upstream FIFO into PACK-lane output beats.
// A sticky flush request drains the FIFO and emits any partial beat marked as last.
module kernel_bc_stream_pack #(
  parameter int DATA_WIDTH = 32,
  parameter int PACK       = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_empty_n,
  output logic                       in_read,
  input  logic [DATA_WIDTH-1:0]      in_dout,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]            out_keep,
  output logic                       out_last,
  output logic                       flush_done,
  output logic [31:0]                word_count
);

  localparam int CNT_W = $clog2(PACK + 1);

  typedef enum logic {
    FILL,
    EMIT
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [CNT_W-1:0]      r_laneCnt;
  logic [DATA_WIDTH-1:0] r_lanes [PACK];
  logic [PACK-1:0]       r_keep;
  logic                  r_last;
  logic                  r_flushPend;
  logic                  r_flushDone;
  logic [31:0]           r_wordCount;

  logic                  w_pop;
  logic                  w_accept;
  logic                  w_full;
  logic                  w_flushBeat;
  logic                  w_flushNone;
  logic [PACK-1:0]       w_partialKeep;

  // A full beat is decided on the pop that fills the last lane; a flush only
  // acts once the FIFO has run dry so that queued words are never stranded.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    w_accept    = 1'b0;
    w_full      = 1'b0;
    w_flushBeat = 1'b0;
    w_flushNone = 1'b0;
    case (r_state)
      FILL: begin
        if (in_empty_n) begin
          w_pop = 1'b1;
          if (r_laneCnt == CNT_W'(PACK - 1)) begin
            w_full      = 1'b1;
            w_nextState = EMIT;
          end
        end else if (r_flushPend) begin
          if (r_laneCnt != '0) begin
            w_flushBeat = 1'b1;
            w_nextState = EMIT;
          end else begin
            w_flushNone = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          w_accept    = 1'b1;
          w_nextState = FILL;
        end
      end
      default: w_nextState = FILL;
    endcase
  end

  always_comb begin
    w_partialKeep = '0;
    for (int i = 0; i < PACK; i++) begin
      w_partialKeep[i] = (CNT_W'(i) < r_laneCnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= FILL;
      r_laneCnt   <= '0;
      r_keep      <= '0;
      r_last      <= 1'b0;
      r_flushPend <= 1'b0;
      r_flushDone <= 1'b0;
      r_wordCount <= '0;
      for (int i = 0; i < PACK; i++) begin
        r_lanes[i] <= '0;
      end
    end else begin
      r_state     <= w_nextState;
      r_flushDone <= w_flushNone | (w_accept & r_last);
      // Completion wins over a simultaneous re-request so a held flush cannot retrigger.
      if (w_flushNone || (w_accept && r_last)) begin
        r_flushPend <= 1'b0;
      end else if (flush) begin
        r_flushPend <= 1'b1;
      end
      if (w_pop) begin
        r_laneCnt   <= r_laneCnt + CNT_W'(1);
        r_wordCount <= r_wordCount + 32'd1;
      end
      if (w_accept) begin
        r_laneCnt <= '0;
        r_keep    <= '0;
        r_last    <= 1'b0;
        for (int i = 0; i < PACK; i++) begin
          r_lanes[i] <= '0;
        end
      end else begin
        for (int i = 0; i < PACK; i++) begin
          if (w_pop && r_laneCnt == CNT_W'(i)) begin
            r_lanes[i] <= in_dout;
          end
        end
      end
      if (w_full) begin
        r_keep <= '1;
        r_last <= 1'b0;
      end
      if (w_flushBeat) begin
        r_keep <= w_partialKeep;
        r_last <= 1'b1;
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < PACK; i++) begin
      out_data[i*DATA_WIDTH +: DATA_WIDTH] = r_lanes[i];
    end
  end

  assign in_read    = w_pop & reset_n;
  assign out_valid  = (r_state == EMIT);
  assign out_keep   = r_keep;
  assign out_last   = r_last;
  assign flush_done = r_flushDone;
  assign word_count = r_wordCount;

endmodule

// File: tb/tb_kernel_bc_stream_pack.sv
// Directed bench for kernel_bc_stream_pack: FIFO model drives the input, expected
// beats are derived from the pushed word list, and a negedge process checks every cycle.
module tb_kernel_bc_stream_pack;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_empty_n;
  logic         in_read;
  logic [31:0]  in_dout;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_keep;
  logic         out_last;
  logic         flush_done;
  logic [31:0]  word_count;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
  } beat_t;

  beat_t        expBeats[$];
  logic [31:0]  fifo[$];
  logic [31:0]  stimWords[$];
  int           checks = 0;
  int           errors = 0;
  logic [31:0]  expCount = '0;
  int           beatCount = 0;
  int           doneCount = 0;
  int           validCycles = 0;
  logic         prevHold = 1'b0;
  logic [127:0] prevData = '0;
  logic [3:0]   prevKeep = '0;
  logic         prevLast = 1'b0;
  logic [127:0] lastData = '0;
  int           beatBase;
  int           doneBase;
  int           validBase;

  always #5 clk = ~clk;

  kernel_bc_stream_pack #(.DATA_WIDTH(32), .PACK(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_empty_n (in_empty_n),
    .in_read    (in_read),
    .in_dout    (in_dout),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_last   (out_last),
    .flush_done (flush_done),
    .word_count (word_count)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refreshFifo();
    in_empty_n = (fifo.size() != 0);
    in_dout    = (fifo.size() != 0) ? fifo[0] : 32'd0;
  endtask

  task automatic applyStimulus();
    logic doPop;
    @(negedge clk);
    #1;
    doPop = in_read && in_empty_n;
    @(posedge clk);
    #1;
    if (doPop && fifo.size() > 0) fifo.delete(0);
    flush = 1'b0;
    refreshFifo();
  endtask

  // Expected beats: consecutive groups of four words; a leftover group becomes a
  // last-marked partial beat only if a flush covers it.
  task automatic loadWords(input bit fl);
    int    n;
    int    cnt;
    beat_t bt;
    n = stimWords.size();
    for (int b = 0; b < n; b += 4) begin
      cnt     = (n - b >= 4) ? 4 : n - b;
      bt.data = '0;
      bt.keep = '0;
      for (int j = 0; j < cnt; j++) begin
        bt.data[j*32 +: 32] = stimWords[b+j];
        bt.keep[j]          = 1'b1;
      end
      bt.last = (cnt < 4);
      if (cnt == 4 || fl) expBeats.push_back(bt);
    end
    foreach (stimWords[k]) fifo.push_back(stimWords[k]);
    stimWords.delete();
    refreshFifo();
  endtask

  task automatic waitIdle(input int budget, input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fifo.size() == 0 && expBeats.size() == 0 && !out_valid) begin
        idle = 1'b1;
        break;
      end
      applyStimulus();
    end
    checkOutput(name, 128'(idle), 128'(1));
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      checkOutput("in_read_in_reset", 128'(in_read), 128'(0));
      expCount = '0;
      prevHold = 1'b0;
    end else begin
      checkOutput("word_count", 128'(word_count), 128'(expCount));
      if (out_valid) checkOutput("in_read_emit", 128'(in_read), 128'(0));
      else           checkOutput("in_read_fill", 128'(in_read), 128'(in_empty_n));
      if (prevHold) begin
        checkOutput("hold_valid", 128'(out_valid), 128'(1));
        checkOutput("hold_data", out_data, prevData);
        checkOutput("hold_keep", 128'(out_keep), 128'(prevKeep));
        checkOutput("hold_last", 128'(out_last), 128'(prevLast));
      end
      if (out_valid) begin
        logic [127:0] mask;
        for (int j = 0; j < 4; j++) mask[j*32 +: 32] = {32{out_keep[j]}};
        checkOutput("unused_lanes_zero", out_data & ~mask, 128'(0));
        validCycles++;
      end
      if (out_valid && out_ready) begin
        if (expBeats.size() == 0) begin
          checkOutput("unexpected_beat", 128'(1), 128'(0));
        end else begin
          checkOutput("beat_data", out_data, expBeats[0].data);
          checkOutput("beat_keep", 128'(out_keep), 128'(expBeats[0].keep));
          checkOutput("beat_last", 128'(out_last), 128'(expBeats[0].last));
          expBeats.delete(0);
        end
        lastData = out_data;
        beatCount++;
      end
      if (flush_done) doneCount++;
      prevHold = out_valid && !out_ready;
      prevData = out_data;
      prevKeep = out_keep;
      prevLast = out_last;
      if (in_read && in_empty_n) expCount = expCount + 32'd1;
    end
  end

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    refreshFifo();
    applyStimulus();
    applyStimulus();
    reset_n = 1'b1;

    checkOutput("rst_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_keep", 128'(out_keep), 128'(0));
    checkOutput("rst_last", 128'(out_last), 128'(0));
    checkOutput("rst_done", 128'(flush_done), 128'(0));
    checkOutput("rst_count", 128'(word_count), 128'(0));
    checkOutput("rst_data", out_data, 128'(0));

    // Single full beat and its latency
    $display("[TB] full beat of 1..4");
    out_ready = 1'b1;
    stimWords = '{32'd1, 32'd2, 32'd3, 32'd4};
    loadWords(1'b0);
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("lat_before_4th", 128'(out_valid), 128'(0));
    applyStimulus();
    checkOutput("lat_after_4th", 128'(out_valid), 128'(1));
    checkOutput("t1_keep", 128'(out_keep), 128'(4'b1111));
    checkOutput("t1_last", 128'(out_last), 128'(0));
    waitIdle(20, "t1_idle");
    checkOutput("t1_data", lastData, 128'h00000004_00000003_00000002_00000001);
    checkOutput("t1_count", 128'(word_count), 128'(4));

    // Backpressure on the first of two beats
    $display("[TB] backpressure");
    out_ready = 1'b0;
    beatBase  = beatCount;
    for (int i = 0; i < 8; i++) stimWords.push_back(32'h10 + 32'(i));
    loadWords(1'b0);
    for (int i = 0; i < 4; i++) applyStimulus();
    for (int i = 0; i < 10; i++) applyStimulus();
    checkOutput("bp_valid_held", 128'(out_valid), 128'(1));
    checkOutput("bp_no_pops", 128'(fifo.size()), 128'(4));
    checkOutput("bp_no_beats", 128'(beatCount - beatBase), 128'(0));
    out_ready = 1'b1;
    waitIdle(30, "bp_idle");
    checkOutput("bp_beats", 128'(beatCount - beatBase), 128'(2));
    checkOutput("bp_last_data", lastData, 128'h00000017_00000016_00000015_00000014);

    // Partial flush beat
    $display("[TB] partial flush");
    doneBase  = doneCount;
    stimWords = '{32'hA, 32'hB};
    loadWords(1'b1);
    applyStimulus();
    applyStimulus();
    flush = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("pf_valid", 128'(out_valid), 128'(1));
    checkOutput("pf_keep", 128'(out_keep), 128'(4'b0011));
    checkOutput("pf_last", 128'(out_last), 128'(1));
    checkOutput("pf_data", out_data, 128'h0000000B_0000000A);
    applyStimulus();
    checkOutput("pf_done_pulse", 128'(flush_done), 128'(1));
    checkOutput("pf_valid_drop", 128'(out_valid), 128'(0));
    applyStimulus();
    checkOutput("pf_done_clear", 128'(flush_done), 128'(0));
    checkOutput("pf_done_once", 128'(doneCount - doneBase), 128'(1));

    // Flush with nothing buffered
    $display("[TB] empty flush");
    doneBase  = doneCount;
    validBase = validCycles;
    flush     = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("ef_done_pulse", 128'(flush_done), 128'(1));
    for (int i = 0; i < 5; i++) applyStimulus();
    checkOutput("ef_done_once", 128'(doneCount - doneBase), 128'(1));
    checkOutput("ef_no_valid", 128'(validCycles - validBase), 128'(0));

    // Flush raised at the first of six pushes
    $display("[TB] drain six words");
    doneBase = doneCount;
    beatBase = beatCount;
    for (int i = 0; i < 6; i++) stimWords.push_back(32'h21 + 32'(i));
    loadWords(1'b1);
    flush = 1'b1;
    waitIdle(40, "d6_idle");
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("d6_beats", 128'(beatCount - beatBase), 128'(2));
    checkOutput("d6_done_once", 128'(doneCount - doneBase), 128'(1));
    checkOutput("d6_last_data", lastData, 128'h00000026_00000025);

    // Flush covering exactly one full beat leaves nothing partial
    $display("[TB] drain four words");
    doneBase = doneCount;
    beatBase = beatCount;
    for (int i = 0; i < 4; i++) stimWords.push_back(32'h51 + 32'(i));
    loadWords(1'b1);
    flush = 1'b1;
    waitIdle(40, "d4_idle");
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("d4_beats", 128'(beatCount - beatBase), 128'(1));
    checkOutput("d4_done_once", 128'(doneCount - doneBase), 128'(1));

    // Reset discards a partially filled beat
    $display("[TB] reset mid fill");
    beatBase  = beatCount;
    stimWords = '{32'h31, 32'h32, 32'h33};
    loadWords(1'b0);
    for (int i = 0; i < 3; i++) applyStimulus();
    stimWords = '{32'h41, 32'h42, 32'h43, 32'h44};
    loadWords(1'b0);
    reset_n = 1'b0;
    applyStimulus();
    reset_n = 1'b1;
    checkOutput("rm_no_pop_in_reset", 128'(fifo.size()), 128'(4));
    checkOutput("rm_count_zero", 128'(word_count), 128'(0));
    waitIdle(30, "rm_idle");
    checkOutput("rm_beats", 128'(beatCount - beatBase), 128'(1));
    checkOutput("rm_data", lastData, 128'h00000044_00000043_00000042_00000041);
    checkOutput("rm_count", 128'(word_count), 128'(4));

    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
